contador_bits_prog: RTL and testbench

- Parametrised, programmable down-counter for SPI bit/byte sequencing in the peripheral subsystem.
- Loads a start value and counts down on qualified enable ticks.
- Emits a one-cycle terminal pulse when the count expires.
- Supports one-shot and auto-reload modes, restart/abort control and status flags.

---
 rtl/contador_bits_prog.sv | 85 ++++++++
 tb/tb_contador_bits_prog.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/contador_bits_prog.sv
// Programmable down-counter for SPI bit/byte sequencing: one-shot or auto-reload,
// with a one-cycle terminal pulse. Define CONTADOR_PRESC_EN to add a tick prescaler.
module contador_bits_prog #(
  parameter int WIDTH = 3,
`ifdef CONTADOR_PRESC_EN
  parameter int PRESC_W = 4,
`endif
  parameter logic [WIDTH-1:0] DEFAULT_LOAD = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst,
`ifdef CONTADOR_PRESC_EN
  input  logic [PRESC_W-1:0] presc_i,
`endif
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             reload_i,
  input  logic             en_i,
  input  logic             stop_i,
  output logic [WIDTH-1:0] count_o,
  output logic             en_bit_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] load_q;
  logic             tick;

`ifdef CONTADOR_PRESC_EN
  logic [PRESC_W-1:0] presc_q;

  // Prescaler only runs in RUN; any control event or leaving RUN restarts the divide.
  always_ff @(posedge clk_i) begin
    if (!rst || stop_i || start_i || state != RUN)
      presc_q <= '0;
    else if (en_i)
      presc_q <= (presc_q == presc_i) ? '0 : presc_q + 1'b1;
  end

  assign tick = en_i && (presc_q == presc_i);
`else
  assign tick = en_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state    <= IDLE;
      count_o  <= DEFAULT_LOAD;
      load_q   <= DEFAULT_LOAD;
      en_bit_o <= 1'b0;
    end else begin
      en_bit_o <= 1'b0;
      if (stop_i) begin
        state <= IDLE;
      end else if (start_i) begin
        count_o <= load_val_i;
        load_q  <= load_val_i;
        state   <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (tick) begin
              if (count_o != '0) begin
                count_o <= count_o - 1'b1;
              end else begin
                en_bit_o <= 1'b1;
                if (reload_i) count_o <= load_q;
                else          state   <= DONE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o = (state == RUN);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_contador_bits_prog.sv
// Scoreboard bench for contador_bits_prog: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_contador_bits_prog;

  logic       clk_i = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic [2:0] load_val_i = '0;
  logic       reload_i = 1'b0;
  logic       en_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [2:0] count_o;
  logic       en_bit_o, busy_o, done_o;
`ifdef CONTADOR_PRESC_EN
  logic [3:0] presc_i = '0;
`endif

  always #50 clk_i = ~clk_i;

  contador_bits_prog dut (
    .clk_i(clk_i), .rst(rst),
`ifdef CONTADOR_PRESC_EN
    .presc_i(presc_i),
`endif
    .start_i(start_i), .load_val_i(load_val_i), .reload_i(reload_i),
    .en_i(en_i), .stop_i(stop_i), .count_o(count_o),
    .en_bit_o(en_bit_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {int cnt; int pulse; int busy; int done;} exp_t;
  exp_t sb_q[$];

  int n_tests = 0, n_fail = 0;
  int ms = 0, mc = 7, ml = 7, mpc = 0;  // model state (0 idle,1 run,2 done), count, load, prescale
  int n_pulse = 0, n_done = 0, first_pulse = 0, cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model;
    bit tick;
    int mp;
    mp = 0;
    if (!rst) begin
      ms = 0; mc = 7; ml = 7; mpc = 0;
    end else begin
      tick = 0;
      if (ms == 1 && en_i) begin
`ifdef CONTADOR_PRESC_EN
        if (mpc == int'(presc_i)) begin tick = 1; mpc = 0; end
        else mpc++;
`else
        tick = 1;
`endif
      end
      if (stop_i) ms = 0;
      else if (start_i) begin mc = int'(load_val_i); ml = mc; ms = 1; mpc = 0; end
      else if (ms == 1) begin
        if (tick) begin
          if (mc != 0) mc--;
          else begin
            mp = 1;
            if (reload_i) mc = ml;
            else ms = 2;
          end
        end
      end else if (ms == 2) ms = 0;
      if (ms != 1) mpc = 0;
    end
    sb_q.push_back('{mc, mp, (ms == 1) ? 1 : 0, (ms == 2) ? 1 : 0});
  endtask

  task automatic step(input bit r, input bit sa, input int lv, input bit rl,
                      input bit en, input bit st);
    exp_t e;
    @(negedge clk_i);
    rst = r; start_i = sa; load_val_i = 3'(lv); reload_i = rl; en_i = en; stop_i = st;
    model();
    @(posedge clk_i);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("count", int'(count_o), e.cnt);
      chk("en_bit", int'(en_bit_o), e.pulse);
      chk("busy", int'(busy_o), e.busy);
      chk("done", int'(done_o), e.done);
    end
    if (en_bit_o) begin
      n_pulse++;
      if (first_pulse == 0) first_pulse = cyc;
    end
    if (done_o) n_done++;
  endtask

  task automatic clr_stats;
    n_pulse = 0; n_done = 0; first_pulse = 0; cyc = 0;
  endtask

  initial begin
    // reset, then en_i in IDLE must not move the count
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("rst_count", int'(count_o), 7);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("idle_hold", int'(count_o), 7);

    // one-shot, load 7: pulse after the 8th tick edge
    step(1, 1, 7, 0, 0, 0);
    clr_stats();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 0);
    chk("os_pulse_at", first_pulse, 8);
    chk("os_pulses", n_pulse, 1);
    chk("os_done", n_done, 1);
    chk("os_idle_busy", int'(busy_o), 0);

    // auto-reload, load 3, 20 ticks: 5 pulses, no done
    step(1, 1, 3, 1, 0, 0);
    clr_stats();
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 1, 0);
    chk("ar_pulses", n_pulse, 5);
    chk("ar_first", first_pulse, 4);
    chk("ar_done", n_done, 0);
    step(1, 0, 0, 1, 0, 1);

    // gapped enable, load 2: pulse on the 3rd enabled edge (cycle 5)
    step(1, 1, 2, 0, 0, 0);
    clr_stats();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, (i % 2) == 0, 0);
    chk("gap_first", first_pulse, 5);
    chk("gap_pulses", n_pulse, 1);

    // stop at count 4
    step(1, 1, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
    clr_stats();
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    chk("stop_cnt", int'(count_o), 4);
    chk("stop_busy", int'(busy_o), 0);
    chk("stop_pulse", n_pulse, 0);

    // restart at count 1 with load 5
    step(1, 1, 7, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, 0);
    chk("pre_restart", int'(count_o), 1);
    clr_stats();
    step(1, 1, 5, 0, 1, 0);
    chk("restart_cnt", int'(count_o), 5);
    chk("restart_pulse", n_pulse, 0);

    // reset at count 0 with tick pending
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("pre_rst0", int'(count_o), 0);
    clr_stats();
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst0_pulse", n_pulse, 0);
    chk("rst0_cnt", int'(count_o), 7);

`ifdef CONTADOR_PRESC_EN
    presc_i = 4'd2;
    step(1, 1, 1, 0, 0, 0);
    clr_stats();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1, 0);
    chk("presc_first", first_pulse, 6);
    chk("presc_pulses", n_pulse, 1);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
